// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sin/cos rotator and the arctan stage.
// Angles are Q8.24 degrees, x/y carry Q2.30 plus two guard bits.
package cordic_pkg;
  localparam int ITER_DEF = 32;
  localparam int XY_W     = 34;
  localparam int Z_W      = 32;
  localparam int OUT_W    = 32;

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  localparam logic signed [XY_W-1:0] K_CONST = 34'sh026DD3B6A;
  // 180 deg does not fit in signed Q8.24, so the fold constants carry one extra bit
  localparam logic signed [Z_W:0]    DEG90   = 33'sh05A000000;
  localparam logic signed [Z_W:0]    DEG180  = 33'sh0B4000000;

  function automatic logic [OUT_W-1:0] sat32(input logic signed [XY_W:0] v);
    if (v > 35'sh07FFFFFFF) return 32'h7FFFFFFF;
    if (v < -35'sh080000000) return 32'h80000000;
    return v[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/cordic_atan_lut.sv
// atan(2^-i) in Q8.24 degrees, rounded to nearest; zero for i >= 32.
// Pure combinational so the arctan stage can share it.
module cordic_atan_lut #(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      atan
);
  function automatic logic [31:0] lut32(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h2D000000;
      5'd1:  return 32'h1A90A732;
      5'd2:  return 32'h0E094740;
      5'd3:  return 32'h07200112;
      5'd4:  return 32'h03938AA6;
      5'd5:  return 32'h01CA3795;
      5'd6:  return 32'h00E52A1B;
      5'd7:  return 32'h007296D8;
      5'd8:  return 32'h00394BA5;
      5'd9:  return 32'h001CA5DA;
      5'd10: return 32'h000E52EE;
      5'd11: return 32'h00072977;
      5'd12: return 32'h000394BC;
      5'd13: return 32'h0001CA5E;
      5'd14: return 32'h0000E52F;
      5'd15: return 32'h00007297;
      5'd16: return 32'h0000394C;
      5'd17: return 32'h00001CA6;
      5'd18: return 32'h00000E53;
      5'd19: return 32'h00000729;
      5'd20: return 32'h00000395;
      5'd21: return 32'h000001CA;
      5'd22: return 32'h000000E5;
      5'd23: return 32'h00000073;
      5'd24: return 32'h00000039;
      5'd25: return 32'h0000001D;
      5'd26: return 32'h0000000E;
      5'd27: return 32'h00000007;
      5'd28: return 32'h00000004;
      5'd29: return 32'h00000002;
      5'd30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  logic [31:0] ix;

  always_comb begin
    ix   = 32'(idx);
    atan = (ix < 32'd32) ? lut32(ix[4:0]) : 32'h0;
  end
endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC rotator: one micro-rotation per clock, angle folded into
// +/-90 deg first and the result negated back for the outer quadrants.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] angle,
  output logic        out_valid,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t                   state, state_nx;
  logic [CNT_W-1:0]         cnt;
  logic signed [XY_W-1:0]   x, y, x_sh, y_sh, x_nx, y_nx;
  logic signed [Z_W-1:0]    z, z_nx, z0;
  logic signed [Z_W:0]      a_ext;
  logic signed [XY_W:0]     xe, ye;
  logic [31:0]              atan_w;
  logic                     neg, neg0, accept, last, d;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ROT;
      ROT:     if (last)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Exactly +/-90 stays in the direct path; only strictly outer angles fold.
  always_comb begin
    a_ext = $signed({angle[31], angle});
    z0    = $signed(angle);
    neg0  = 1'b0;
    if (a_ext > DEG90) begin
      z0   = 32'(a_ext - DEG180);
      neg0 = 1'b1;
    end else if (a_ext < -DEG90) begin
      z0   = 32'(a_ext + DEG180);
      neg0 = 1'b1;
    end
  end

  cordic_atan_lut #(.IDX_W(CNT_W)) u_lut (
    .idx  (cnt),
    .atan (atan_w)
  );

  always_comb begin
    d    = ~z[Z_W-1];
    x_sh = x >>> cnt;
    y_sh = y >>> cnt;
    x_nx = d ? (x - y_sh) : (x + y_sh);
    y_nx = d ? (y + x_sh) : (y - x_sh);
    z_nx = d ? (z - $signed(atan_w)) : (z + $signed(atan_w));
    xe   = neg ? -(35'(x_nx)) : 35'(x_nx);
    ye   = neg ? -(35'(y_nx)) : 35'(y_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      neg     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        cnt <= '0;
        x   <= K_CONST;
        y   <= '0;
        z   <= z0;
        neg <= neg0;
      end
    end else if (state == ROT) begin
      cnt <= cnt + 1'b1;
      x   <= x_nx;
      y   <= y_nx;
      z   <= z_nx;
      if (last) begin
        cos_out <= sat32(xe);
        sin_out <= sat32(ye);
      end
    end
  end
endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: latency, quadrant folding, ignored
// requests, back-to-back throughput and mid-rotation reset.
module tb_cordic_sincos;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle;
  logic        out_valid;
  logic [31:0] cos_out;
  logic [31:0] sin_out;

  int checks = 0;
  int errors = 0;

  cordic_sincos #(.ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .out_valid (out_valid),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    longint dlt;
    logic   ok;
    dlt = longint'($signed(obs)) - longint'($signed(exp));
    ok  = (dlt <= 64) && (dlt >= -64);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: got %h expected %h +/-64", tag, obs, exp);
    end
  endtask

  // One request; optional spurious in_valid pulse in ROT at cycle noise_at.
  task automatic run_op(input string tag, input logic [31:0] ang,
                        input logic [31:0] ec, input logic [31:0] es, input int noise_at);
    int n;
    in_valid = 1'b1;
    angle    = ang;
    step();
    in_valid = 1'b0;
    angle    = 32'h0;
    n = 1;
    while (!out_valid && n < 100) begin
      if (noise_at > 0 && n == noise_at) begin
        in_valid = 1'b1;
        angle    = 32'h78000000;
      end
      if (noise_at > 0 && n == noise_at + 3) begin
        in_valid = 1'b0;
        angle    = 32'h0;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    chk_eq({tag, "_latency"}, 32'(n), 32'd33);
    chk_near({tag, "_cos"}, cos_out, ec);
    chk_near({tag, "_sin"}, sin_out, es);
    step();
    chk_eq({tag, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
    chk_eq({tag, "_hold_cos"}, cos_out, cos_out === 32'hx ? 32'h0 : cos_out);
  endtask

  initial begin
    int n, gap;
    int seen;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    angle    = 32'h0;
    step();
    step();
    chk_eq("rst_cos", cos_out, 32'h0);
    chk_eq("rst_sin", sin_out, 32'h0);
    chk_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("zero",  32'h00000000, 32'h40000000, 32'h00000000, 0);
    run_op("p30",   32'h1E000000, 32'h376CF5D1, 32'h20000000, 0);
    run_op("m45",   32'hD3000000, 32'h2D413CCD, 32'hD2BEC333, 0);
    run_op("p120",  32'h78000000, 32'hE0000000, 32'h376CF5D1, 0);
    run_op("m120",  32'h88000000, 32'hE0000000, 32'hC8930A2F, 0);
    run_op("p90",   32'h5A000000, 32'h00000000, 32'h40000000, 0);
    run_op("m90",   32'hA6000000, 32'h00000000, 32'hC0000000, 0);
    run_op("ignore", 32'h1E000000, 32'h376CF5D1, 32'h20000000, 10);
    chk_eq("ignore_ready", {31'd0, in_ready}, 32'd1);

    // in_valid held high: pulses must be ITER+2 cycles apart
    in_valid = 1'b1;
    angle    = 32'h00000000;
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk_near("b2b_first_cos", cos_out, 32'h40000000);
    step();
    gap = 1;
    while (!out_valid && gap < 100) begin step(); gap++; end
    in_valid = 1'b0;
    chk_eq("b2b_gap", 32'(gap), 32'd34);
    chk_near("b2b_second_cos", cos_out, 32'h40000000);
    step();
    chk_eq("b2b_idle_ready", {31'd0, in_ready}, 32'd1);

    // reset in the middle of a rotation
    in_valid = 1'b1;
    angle    = 32'h1E000000;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 15; k++) step();
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_cos", cos_out, 32'h0);
    chk_eq("mid_rst_sin", sin_out, 32'h0);
    chk_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk_eq("mid_rst_no_pulse", 32'(seen), 32'd0);
    run_op("after_rst", 32'hD3000000, 32'h2D413CCD, 32'hD2BEC333, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
